// File: rtl/pipeline_alu_arbiter_if.sv
// Bundle of the two requester ports, the hold control and the tagged response bus
// of pipeline_alu_arbiter. The master side is the issue logic, the slave side is the arbiter.
interface pipeline_alu_arbiter_if;
   logic       req0;
   logic [7:0] fncode0;
   logic [3:0] srca0;
   logic [3:0] srcb0;
   logic       gnt0;
   logic       req1;
   logic [7:0] fncode1;
   logic [3:0] srca1;
   logic [3:0] srcb1;
   logic       gnt1;
   logic       hold;
   logic       resp_valid;
   logic       resp_id;
   logic [3:0] resp_alu;
   logic       resp_parity;
   logic       resp_err;
   logic [1:0] inflight;

   modport master (
      output req0, fncode0, srca0, srcb0,
      output req1, fncode1, srca1, srcb1,
      output hold,
      input  gnt0, gnt1,
      input  resp_valid, resp_id, resp_alu, resp_parity, resp_err, inflight
   );

   modport slave (
      input  req0, fncode0, srca0, srcb0,
      input  req1, fncode1, srca1, srcb1,
      input  hold,
      output gnt0, gnt1,
      output resp_valid, resp_id, resp_alu, resp_parity, resp_err, inflight
   );
endinterface

// File: rtl/pipeline_alu_arbiter.sv
// Two-requester arbiter feeding the IF_EX / EX_PAR pipeline of the 4-bit ALU/parity datapath.
// Define PIPE_ARB_RR_EN for round-robin contention resolution; otherwise requester 0 has fixed priority.
module pipeline_alu_arbiter (
   input logic                    clk,
   input logic                    rst_n,
   pipeline_alu_arbiter_if.slave  bus
);

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_NAND = 3'd6;
   localparam logic [2:0] OP_XNOR = 3'd7;

   // Returns {err, opcode}; anything not one-hot is flagged and mapped to opcode 0.
   function automatic logic [3:0] decode_fn(input logic [7:0] fn);
      logic [3:0] res;
      res = {1'b0, OP_ADD};
      case (fn)
         8'b0000_0001: res = {1'b0, OP_ADD};
         8'b0000_0010: res = {1'b0, OP_SUB};
         8'b0000_0100: res = {1'b0, OP_XOR};
         8'b0000_1000: res = {1'b0, OP_OR};
         8'b0001_0000: res = {1'b0, OP_AND};
         8'b0010_0000: res = {1'b0, OP_NOR};
         8'b0100_0000: res = {1'b0, OP_NAND};
         8'b1000_0000: res = {1'b0, OP_XNOR};
         default:      res = {1'b1, OP_ADD};
      endcase
      return res;
   endfunction

   logic       req_w [2];
   logic [7:0] fn_w  [2];
   logic [3:0] a_w   [2];
   logic [3:0] b_w   [2];
   logic [3:0] dec_w [2];

   assign req_w[0] = bus.req0;
   assign fn_w[0]  = bus.fncode0;
   assign a_w[0]   = bus.srca0;
   assign b_w[0]   = bus.srcb0;
   assign req_w[1] = bus.req1;
   assign fn_w[1]  = bus.fncode1;
   assign a_w[1]   = bus.srca1;
   assign b_w[1]   = bus.srcb1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dec
         assign dec_w[gi] = decode_fn(fn_w[gi]);
      end
   endgenerate

   // Arbitration: prio0 says whether requester 0 wins a contended cycle.
   logic prio0;
   logic gnt0_w;
   logic gnt1_w;
   logic grant_any;
   logic grant_id;

`ifdef PIPE_ARB_RR_EN
   // rr_q names the requester that wins the next contention.
   logic rr_q;
   logic rr_d;

   assign prio0 = ~rr_q;

   always_comb begin
      rr_d = rr_q;
      if (grant_any) begin
         rr_d = ~grant_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   assign prio0 = 1'b1;
`endif

   always_comb begin
      gnt0_w = 1'b0;
      gnt1_w = 1'b0;
      if (rst_n && !bus.hold) begin
         if (req_w[0] && (!req_w[1] || prio0)) begin
            gnt0_w = 1'b1;
         end else if (req_w[1]) begin
            gnt1_w = 1'b1;
         end
      end
   end

   assign grant_any = gnt0_w | gnt1_w;
   assign grant_id  = gnt1_w;
   assign bus.gnt0  = gnt0_w;
   assign bus.gnt1  = gnt1_w;

   // IF_EX stage: opcode + operands plus id/err sideband.
   logic       if_v_q,   if_v_d;
   logic       if_id_q,  if_id_d;
   logic       if_err_q, if_err_d;
   logic [2:0] if_op_q,  if_op_d;
   logic [3:0] if_a_q,   if_a_d;
   logic [3:0] if_b_q,   if_b_d;

   // EX_PAR stage: ALU result plus id/err sideband.
   logic       ex_v_q,   ex_v_d;
   logic       ex_id_q,  ex_id_d;
   logic       ex_err_q, ex_err_d;
   logic [3:0] ex_alu_q, ex_alu_d;

   logic [3:0] alu_w;

   always_comb begin
      alu_w = 4'd0;
      case (if_op_q)
         OP_ADD:  alu_w = if_a_q + if_b_q;
         OP_SUB:  alu_w = if_a_q - if_b_q;
         OP_XOR:  alu_w = if_a_q ^ if_b_q;
         OP_OR:   alu_w = if_a_q | if_b_q;
         OP_AND:  alu_w = if_a_q & if_b_q;
         OP_NOR:  alu_w = ~(if_a_q | if_b_q);
         OP_NAND: alu_w = ~(if_a_q & if_b_q);
         OP_XNOR: alu_w = ~(if_a_q ^ if_b_q);
         default: alu_w = 4'd0;
      endcase
      // An invalid function code always yields a zero result.
      if (if_err_q) begin
         alu_w = 4'd0;
      end
   end

   always_comb begin
      if_v_d   = if_v_q;
      if_id_d  = if_id_q;
      if_err_d = if_err_q;
      if_op_d  = if_op_q;
      if_a_d   = if_a_q;
      if_b_d   = if_b_q;
      ex_v_d   = ex_v_q;
      ex_id_d  = ex_id_q;
      ex_err_d = ex_err_q;
      ex_alu_d = ex_alu_q;
      if (!bus.hold) begin
         if_v_d = grant_any;
         if (grant_any) begin
            if_id_d  = grant_id;
            if_err_d = dec_w[grant_id][3];
            if_op_d  = dec_w[grant_id][2:0];
            if_a_d   = a_w[grant_id];
            if_b_d   = b_w[grant_id];
         end
         ex_v_d = if_v_q;
         if (if_v_q) begin
            ex_id_d  = if_id_q;
            ex_err_d = if_err_q;
            ex_alu_d = alu_w;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_v_q   <= 1'b0;
         if_id_q  <= 1'b0;
         if_err_q <= 1'b0;
         if_op_q  <= 3'd0;
         if_a_q   <= 4'd0;
         if_b_q   <= 4'd0;
         ex_v_q   <= 1'b0;
         ex_id_q  <= 1'b0;
         ex_err_q <= 1'b0;
         ex_alu_q <= 4'd0;
      end else begin
         if_v_q   <= if_v_d;
         if_id_q  <= if_id_d;
         if_err_q <= if_err_d;
         if_op_q  <= if_op_d;
         if_a_q   <= if_a_d;
         if_b_q   <= if_b_d;
         ex_v_q   <= ex_v_d;
         ex_id_q  <= ex_id_d;
         ex_err_q <= ex_err_d;
         ex_alu_q <= ex_alu_d;
      end
   end

   assign bus.resp_valid  = ex_v_q & ~bus.hold;
   assign bus.resp_id     = ex_id_q;
   assign bus.resp_alu    = ex_alu_q;
   assign bus.resp_parity = ^ex_alu_q;
   assign bus.resp_err    = ex_err_q;
   assign bus.inflight    = {1'b0, if_v_q} + {1'b0, ex_v_q};

   a_gnt_exclusive: assert property (@(posedge clk) !(gnt0_w && gnt1_w));
   a_no_gnt_on_hold: assert property (@(posedge clk) bus.hold |-> !grant_any);

endmodule
